// File: rtl/zxn_audio_limiter.sv
// zxn_audio_limiter
//   N-channel automatic gain limiter between the ZXN mixer and the audio DAC
//   outputs. Offset-binary samples are captured on ce_sample, widened to OUT_W,
//   scaled by a per-domain gain (256 = unity) through a single multiplier that
//   walks the channels one per clock, then committed to audio_out together.
//   Gain drops quickly while the signal is over THRESH and recovers by one
//   step per RELEASE_SAMPLES clean samples.
//
//   Optional build macro: ZXN_AUDIO_LIMITER_STEREO_LINK_EN
//     defined   - one gain/release counter shared by all channels; any
//                 over-threshold channel attenuates every channel.
//     undefined - an independent gain/release counter per channel; gain_o
//                 reports the channel 0 gain.
module zxn_audio_limiter #(
  parameter int CHANNELS        = 2,
  parameter int IN_W            = 12,
  parameter int OUT_W           = 16,
  parameter int THRESH          = 24576,
  parameter int ATTACK_STEP     = 8,
  parameter int GAIN_MIN        = 32,
  parameter int RELEASE_SAMPLES = 1024
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      ce_sample,
  input  logic [CHANNELS*IN_W-1:0]  audio_in,
  input  logic                      ovr_clr,
  output logic [CHANNELS*OUT_W-1:0] audio_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic [8:0]                gain_o
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (RELEASE_SAMPLES > 1) ? $clog2(RELEASE_SAMPLES) : 1;
  localparam int PW    = OUT_W + 10;

`ifdef ZXN_AUDIO_LIMITER_STEREO_LINK_EN
  localparam int NG = 1;
`else
  localparam int NG = CHANNELS;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PROC   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_SAMPLES - 1);
  localparam logic [OUT_W:0]   THRESH_V = (OUT_W + 1)'(THRESH);
  localparam logic [8:0]       UNITY    = 9'd256;
  localparam logic [8:0]       ATK      = 9'(ATTACK_STEP);
  localparam logic [8:0]       GMIN     = 9'(GAIN_MIN);
  localparam logic [OUT_W-1:0] MID      = {1'b1, {(OUT_W-1){1'b0}}};

  // Attack step with the floor applied; computed at 10 bits so the sum
  // GAIN_MIN+ATTACK_STEP cannot wrap.
  function automatic logic [8:0] gain_attack(input logic [8:0] g);
    logic [9:0] lim;
    lim = {1'b0, GMIN} + {1'b0, ATK};
    if ({1'b0, g} >= lim) gain_attack = g - ATK;
    else                  gain_attack = GMIN;
  endfunction

  // Release step, saturating at unity gain.
  function automatic logic [8:0] gain_release(input logic [8:0] g);
    if (g < UNITY) gain_release = g + 9'd1;
    else           gain_release = UNITY;
  endfunction

  // Offset-binary input lane to signed, placed in the top bits of OUT_W
  // (this is the left shift by OUT_W-IN_W).
  function automatic logic signed [OUT_W-1:0] widen(input logic [IN_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    r = '0;
    r[OUT_W-1 -: IN_W] = {~v[IN_W-1], v[IN_W-2:0]};
    widen = r;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic [CHANNELS*IN_W-1:0]   cap_q, cap_d;
  logic [OUT_W-1:0]           res_q [CHANNELS];
  logic [OUT_W-1:0]           res_d [CHANNELS];
  logic [CHANNELS-1:0]        over_q, over_d;
  logic [CHANNELS*OUT_W-1:0]  audio_out_q, audio_out_d;
  logic                       out_valid_q, out_valid_d;
  logic                       overrun_q, overrun_d;
  logic [8:0]                 gain_q [NG];
  logic [8:0]                 gain_d [NG];
  logic [CNT_W-1:0]           cnt_q [NG];
  logic [CNT_W-1:0]           cnt_d [NG];

  logic [IN_W-1:0]            lane_in;
  logic signed [OUT_W-1:0]    xs;
  logic [8:0]                 gain_cur;
  logic signed [PW-1:0]       prod;
  logic signed [OUT_W-1:0]    y;
  logic signed [OUT_W:0]      y_ext;
  logic [OUT_W:0]             y_abs;
  logic [OUT_W-1:0]           lane_out;
  logic                       lane_over;

  // Shared datapath: scale the channel selected by ch_q with the gain held
  // before this sample's commit.
  always_comb begin
    lane_in = cap_q[int'(ch_q)*IN_W +: IN_W];
    xs      = widen(lane_in);
`ifdef ZXN_AUDIO_LIMITER_STEREO_LINK_EN
    gain_cur = gain_q[0];
`else
    gain_cur = gain_q[ch_q];
`endif
    prod     = $signed({{10{xs[OUT_W-1]}}, xs}) * $signed({{(OUT_W+1){1'b0}}, gain_cur});
    // gain <= 256 keeps |y| <= |xs|, so the truncation below never overflows.
    y        = prod[OUT_W+7:8];
    y_ext    = {y[OUT_W-1], y};
    y_abs    = y_ext[OUT_W] ? -y_ext : y_ext;
    lane_out = {~y[OUT_W-1], y[OUT_W-2:0]};
    lane_over = (y_abs > THRESH_V);
  end

  wire unused_prod = ^{prod[PW-1:OUT_W+8], prod[7:0]};

  // Sequencer: capture, serial per-channel processing, commit and gain update.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cap_d       = cap_q;
    res_d       = res_q;
    over_d      = over_q;
    audio_out_d = audio_out_q;
    out_valid_d = 1'b0;
    gain_d      = gain_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (ce_sample) begin
          cap_d   = audio_in;
          ch_d    = '0;
          state_d = ST_PROC;
        end
      end
      ST_PROC: begin
        res_d[ch_q]  = lane_out;
        over_d[ch_q] = lane_over;
        if (ch_q == CH_LAST) begin
          // Results become visible during the COMMIT cycle with the pulse.
          for (int i = 0; i < CHANNELS; i++) audio_out_d[i*OUT_W +: OUT_W] = res_d[i];
          out_valid_d = 1'b1;
          state_d     = ST_COMMIT;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      ST_COMMIT: begin
        for (int g = 0; g < NG; g++) begin
          logic dom_over;
`ifdef ZXN_AUDIO_LIMITER_STEREO_LINK_EN
          dom_over = |over_q;
`else
          dom_over = over_q[g];
`endif
          if (dom_over) begin
            gain_d[g] = gain_attack(gain_q[g]);
            cnt_d[g]  = '0;
          end else if (cnt_q[g] == REL_LAST) begin
            gain_d[g] = gain_release(gain_q[g]);
            cnt_d[g]  = '0;
          end else begin
            cnt_d[g]  = cnt_q[g] + CNT_W'(1);
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe that cannot be accepted is flagged; set beats clear.
    if (ce_sample && (state_q != ST_IDLE)) overrun_d = 1'b1;
    else if (ovr_clr)                      overrun_d = 1'b0;
    else                                   overrun_d = overrun_q;
  end

  // Control and output state, asynchronously reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      audio_out_q <= {CHANNELS{MID}};
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int g = 0; g < NG; g++) begin
        gain_q[g] <= UNITY;
        cnt_q[g]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      audio_out_q <= audio_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      gain_q      <= gain_d;
      cnt_q       <= cnt_d;
    end
  end

  // Sample working storage; always rewritten before use, so left unreset.
  always_ff @(posedge clk_sys) begin
    cap_q  <= cap_d;
    res_q  <= res_d;
    over_q <= over_d;
  end

  assign audio_out = audio_out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = overrun_q;
  assign gain_o    = gain_q[0];

endmodule

// File: tb/tb_zxn_audio_limiter.sv
// Directed bench for zxn_audio_limiter: a vector table for the main scaling
// and attack path, plus short sequences for release, overrun, channel link,
// mid-sample reset and the gain floor (second instance with a low threshold).
module tb_zxn_audio_limiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce_sample, ovr_clr;
  logic [23:0] audio_in;
  logic [31:0] audio_out;
  logic        out_valid, busy, overrun;
  logic [8:0]  gain_o;

  logic        ce_f;
  logic [23:0] in_f;
  logic [31:0] out_f;
  logic        valid_f, busy_f, ovr_f;
  logic [8:0]  gain_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zxn_audio_limiter dut (
    .clk_sys(clk), .reset_n(reset_n), .ce_sample(ce_sample), .audio_in(audio_in),
    .ovr_clr(ovr_clr), .audio_out(audio_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .gain_o(gain_o)
  );

  zxn_audio_limiter #(.THRESH(100), .RELEASE_SAMPLES(4)) dut_f (
    .clk_sys(clk), .reset_n(reset_n), .ce_sample(ce_f), .audio_in(in_f),
    .ovr_clr(ovr_clr), .audio_out(out_f), .out_valid(valid_f), .busy(busy_f),
    .overrun(ovr_f), .gain_o(gain_f)
  );

  typedef struct {
    logic [11:0] a0, a1;
    logic [15:0] e0, e1;
    logic [8:0]  eg;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One sample through the main instance; returns the committed lanes and
  // the cycle (relative to the strobe cycle) at which out_valid was seen.
  // Ends one cycle after COMMIT, when the new gain is visible.
  task automatic run_sample(input logic [11:0] a0, input logic [11:0] a1,
                            output logic [31:0] res, output int lat);
    @(posedge clk); #1;
    audio_in  = {a1, a0};
    ce_sample = 1'b1;
    @(posedge clk); #1;
    ce_sample = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got none expected pulse");
    end
    res = audio_out;
    @(posedge clk); #1;
  endtask

  task automatic run_sample_f(input logic [11:0] v);
    int n;
    @(posedge clk); #1;
    in_f = {v, v};
    ce_f = 1'b1;
    @(posedge clk); #1;
    ce_f = 1'b0;
    n = 1;
    while (!valid_f && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    if (!valid_f) begin
      checks++;
      errors++;
      $display("FAIL floor_valid_timeout: got none expected pulse");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    int seen;

    tbl[0] = '{12'h900, 12'h900, 16'h9000, 16'h9000, 9'd256};
    tbl[1] = '{12'h7FF, 12'h801, 16'h7FF0, 16'h8010, 9'd256};
    tbl[2] = '{12'hFFF, 12'hFFF, 16'hFFF0, 16'hFFF0, 9'd248};
    tbl[3] = '{12'hFFF, 12'hFFF, 16'hFBF0, 16'hFBF0, 9'd240};
    tbl[4] = '{12'hFFF, 12'hFFF, 16'hF7F1, 16'hF7F1, 9'd232};
    tbl[5] = '{12'h000, 12'h000, 16'h0C00, 16'h0C00, 9'd224};
    tbl[6] = '{12'h800, 12'h800, 16'h8000, 16'h8000, 9'd224};
    tbl[7] = '{12'h900, 12'hC00, 16'h8E00, 16'hB800, 9'd224};
    tbl[8] = '{12'h001, 12'h001, 16'h100E, 16'h100E, 9'd216};

    ce_sample = 1'b0; ovr_clr = 1'b0; audio_in = '0;
    ce_f = 1'b0; in_f = '0;
    reset_n = 1'b0;

    // Reset holds everything even while the strobe toggles
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      audio_in  = 24'hFFFFFF;
      ce_sample = ~ce_sample;
    end
    chk("rst_audio_out", audio_out, 32'h8000_8000);
    chk("rst_gain", {23'd0, gain_o}, 32'd256);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    ce_sample = 1'b0;
    #2 reset_n = 1'b1;

    // Vector table: passthrough, scaling and attack
    for (int i = 0; i < 9; i++) begin
      run_sample(tbl[i].a0, tbl[i].a1, r, lat);
      chk($sformatf("vec%0d_ch0", i), {16'd0, r[15:0]}, {16'd0, tbl[i].e0});
      chk($sformatf("vec%0d_ch1", i), {16'd0, r[31:16]}, {16'd0, tbl[i].e1});
      chk($sformatf("vec%0d_gain", i), {23'd0, gain_o}, {23'd0, tbl[i].eg});
      if (i == 0) begin
        chk("latency", lat, 3);
        chk("valid_pulse_end", {31'd0, out_valid}, 32'd0);
        chk("idle_after", {31'd0, busy}, 32'd0);
      end
    end

    // Release: one step after exactly 1024 clean samples
    for (int i = 0; i < 1023; i++) run_sample(12'h800, 12'h800, r, lat);
    chk("release_1023", {23'd0, gain_o}, 32'd216);
    run_sample(12'h800, 12'h800, r, lat);
    chk("release_1024", {23'd0, gain_o}, 32'd217);

    // Overrun: second strobe while busy is dropped, first sample survives
    do_reset();
    @(posedge clk); #1;
    audio_in = {12'hA00, 12'h900};
    ce_sample = 1'b1;
    @(posedge clk); #1;
    audio_in = {12'hFFF, 12'hFFF};
    @(posedge clk); #1;
    ce_sample = 1'b0;
    chk("ovr_set", {31'd0, overrun}, 32'd1);
    chk("ovr_valid_c3", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("ovr_valid_c3b", {31'd0, out_valid}, 32'd1);
    chk("ovr_sample", audio_out, 32'hA000_9000);
    ce_sample = 1'b1;
    ovr_clr   = 1'b1;
    @(posedge clk); #1;
    ce_sample = 1'b0;
    ovr_clr   = 1'b0;
    chk("ovr_set_wins", {31'd0, overrun}, 32'd1);
    chk("ovr_commit_ignored", {31'd0, busy}, 32'd0);
    chk("ovr_gain", {23'd0, gain_o}, 32'd256);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_clear", {31'd0, overrun}, 32'd0);

    // Channel link
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_sample(12'hFFF, 12'h900, r, lat);
      if (i == 0) chk("link_s1_ch1", {16'd0, r[31:16]}, 32'h9000);
    end
`ifdef ZXN_AUDIO_LIMITER_STEREO_LINK_EN
    chk("link_s4_ch1", {16'd0, r[31:16]}, 32'h8E80);
`else
    chk("link_s4_ch1", {16'd0, r[31:16]}, 32'h9000);
`endif
    chk("link_gain", {23'd0, gain_o}, 32'd224);

    // Reset in the middle of a sample aborts it
    @(posedge clk); #1;
    audio_in  = {12'hFFF, 12'hFFF};
    ce_sample = 1'b1;
    @(posedge clk); #1;
    ce_sample = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_gain", {23'd0, gain_o}, 32'd256);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_valid", seen, 0);
    chk("abort_audio_out", audio_out, 32'h8000_8000);

    // Gain floor and full recovery on the low-threshold instance
    for (int i = 0; i < 30; i++) run_sample_f(12'hFFF);
    chk("floor_gain", {23'd0, gain_f}, 32'd32);
    for (int i = 0; i < 3; i++) run_sample_f(12'h800);
    chk("floor_rel_3", {23'd0, gain_f}, 32'd32);
    run_sample_f(12'h800);
    chk("floor_rel_4", {23'd0, gain_f}, 32'd33);
    for (int i = 0; i < 892; i++) run_sample_f(12'h800);
    chk("rel_to_unity", {23'd0, gain_f}, 32'd256);
    for (int i = 0; i < 8; i++) run_sample_f(12'h800);
    chk("rel_hold_unity", {23'd0, gain_f}, 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
